// File: rtl/pipe_pkg.sv
// Purpose : shared types and widths for the pipeline hazard controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: REG_W register-index width, MD_CNT_W mult/div counter width,
//           md_state_t mult/div FSM state enum (IDLE, BUSY).
package pipe_pkg;

  // Matches the forwarding unit's register-index width.
  localparam int REG_W = 6;

  // Wide enough for the largest legal mult/div occupancy (255 cycles).
  localparam int MD_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_tracker.sv
// Purpose : tracks occupancy of the shared multi-cycle mult/div unit.
// Latency : MD_Start at cycle t -> MD_Busy high for cycles t+1 .. t+MD_LAT.
// Backpressure: none here; the caller holds dependent instructions while MD_Busy.
// Ports   : clk, reset (sync, active-high), MD_Start (issue pulse),
//           MD_Busy (registered, high while an operation is in flight).
import pipe_pkg::*;

module md_tracker #(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic MD_Start,
  output logic MD_Busy
);

  md_state_t             state;
  logic [MD_CNT_W-1:0]   cnt;

  // Counter loads MD_LAT-1 on issue; BUSY is left on the cycle after the
  // counter reaches zero, giving exactly MD_LAT busy cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      MD_Busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MD_Start) begin
            state   <= BUSY;
            cnt     <= MD_CNT_W'(MD_LAT - 1);
            MD_Busy <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state   <= IDLE;
            MD_Busy <= 1'b0;
          end else begin
            cnt <= cnt - MD_CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          MD_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose : pipeline sequencing for hazards forwarding cannot fix: load-use
//           stalls, wrong-path squash on jump/taken branch, mult/div scheduling.
// Latency : all controls combinational from current inputs and MD state.
// Backpressure: stalls IF/ID (PC_Wr=0, IFID_Wr=0) and bubbles ID/EX.
// Ports   : clk, reset (sync, active-high); IFID_rs/rt/UsesRt, IDEX_MemRd/rt,
//           ID_Jump, EX_BrTaken, ID_MulDiv, ID_ReadHiLo in; PC_Wr, IFID_Wr,
//           IFID_Flush, IDEX_Flush, MD_Start, MD_Busy out.
// Config  : DELAY_SLOT_EN defined -> the instruction after a jump/branch executes.
import pipe_pkg::*;

module hazard_ctrl #(
  parameter int REG_W  = pipe_pkg::REG_W,
  parameter int MD_LAT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] IFID_rs,
  input  logic [REG_W-1:0] IFID_rt,
  input  logic             IFID_UsesRt,
  input  logic             IDEX_MemRd,
  input  logic [REG_W-1:0] IDEX_rt,
  input  logic             ID_Jump,
  input  logic             EX_BrTaken,
  input  logic             ID_MulDiv,
  input  logic             ID_ReadHiLo,
  output logic             PC_Wr,
  output logic             IFID_Wr,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             MD_Start,
  output logic             MD_Busy
);

  logic load_use;
  logic md_hold;
  logic stall_id;
  logic id_squashed;

  // $0 is hardwired zero, so a load targeting it never creates a dependence.
  assign load_use = IDEX_MemRd && (IDEX_rt != '0) &&
                    ((IDEX_rt == IFID_rs) || (IFID_UsesRt && (IDEX_rt == IFID_rt)));

  assign md_hold  = MD_Busy && (ID_MulDiv || ID_ReadHiLo);
  assign stall_id = load_use || md_hold;

`ifdef DELAY_SLOT_EN
  // With a delay slot the ID instruction behind a taken branch is real work.
  assign id_squashed = 1'b0;
`else
  assign id_squashed = EX_BrTaken;
`endif

  // Issue only a mult/div that is neither held nor on the wrong path.
  assign MD_Start = ID_MulDiv && !stall_id && !reset && !id_squashed;

  always_comb begin
    PC_Wr      = 1'b1;
    IFID_Wr    = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    if (reset) begin
      PC_Wr      = 1'b0;
      IFID_Wr    = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (EX_BrTaken) begin
`ifdef DELAY_SLOT_EN
      if (stall_id) begin
        // Fetch the target while the held delay slot stays in IF/ID.
        IFID_Wr    = 1'b0;
        IDEX_Flush = 1'b1;
      end else begin
        IFID_Flush = 1'b1;
      end
`else
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
`endif
    end else if (stall_id) begin
      // A stalled jump also lands here: it must not redirect yet.
      PC_Wr      = 1'b0;
      IFID_Wr    = 1'b0;
      IDEX_Flush = 1'b1;
    end else if (ID_Jump) begin
`ifndef DELAY_SLOT_EN
      IFID_Flush = 1'b1;
`endif
    end
  end

  // Flushes never reach the tracker, so an issued mult/div always completes
  // unless reset abandons it.
  md_tracker #(
    .MD_LAT (MD_LAT)
  ) u_md_tracker (
    .clk      (clk),
    .reset    (reset),
    .MD_Start (MD_Start),
    .MD_Busy  (MD_Busy)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : self-checking bench for hazard_ctrl (MD_LAT=4).
// Latency : expected outputs queued at drive time, popped at the falling edge.
// Backpressure: n/a.
// Output vector order: {PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, MD_Start, MD_Busy}.
module tb_hazard_ctrl;

  localparam int RW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] IFID_rs, IFID_rt, IDEX_rt;
  logic          IFID_UsesRt, IDEX_MemRd, ID_Jump, EX_BrTaken, ID_MulDiv, ID_ReadHiLo;
  logic          PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, MD_Start, MD_Busy;

  logic [5:0]    sb[$];
  logic [5:0]    exp_v;
  logic [5:0]    outs;
  int            n_checks = 0;
  int            n_errors = 0;

  // Expected control patterns (MD_Busy bit added separately where set).
  localparam logic [5:0] RST  = 6'b001100;
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] STL  = 6'b000100;
  localparam logic [5:0] BRQ  = 6'b111100;
  localparam logic [5:0] JMP  = 6'b111000;
  localparam logic [5:0] ISS  = 6'b110010;

  assign outs = {PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, MD_Start, MD_Busy};

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_W  (RW),
    .MD_LAT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .IFID_rs     (IFID_rs),
    .IFID_rt     (IFID_rt),
    .IFID_UsesRt (IFID_UsesRt),
    .IDEX_MemRd  (IDEX_MemRd),
    .IDEX_rt     (IDEX_rt),
    .ID_Jump     (ID_Jump),
    .EX_BrTaken  (EX_BrTaken),
    .ID_MulDiv   (ID_MulDiv),
    .ID_ReadHiLo (ID_ReadHiLo),
    .PC_Wr       (PC_Wr),
    .IFID_Wr     (IFID_Wr),
    .IFID_Flush  (IFID_Flush),
    .IDEX_Flush  (IDEX_Flush),
    .MD_Start    (MD_Start),
    .MD_Busy     (MD_Busy)
  );

  // Applies one cycle of stimulus and queues the expected outputs for it.
  task automatic drive(input logic rst, input logic memrd, input logic [RW-1:0] ex_rt,
                       input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic uses_rt,
                       input logic jmp, input logic br, input logic md, input logic hl,
                       input logic [5:0] expv);
    reset = rst; IDEX_MemRd = memrd; IDEX_rt = ex_rt; IFID_rs = rs; IFID_rt = rt;
    IFID_UsesRt = uses_rt; ID_Jump = jmp; EX_BrTaken = br; ID_MulDiv = md; ID_ReadHiLo = hl;
    sb.push_back(expv);
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST);
    void'(sb.pop_back());
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0, 1:    drive(1, 1, 5, 5, 0, 0, 1, 1, 1, 1, RST);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      endcase
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (outs !== exp_v) begin
        n_errors++;
        $display("FAIL reset[%0d]: got %b expected %b", i, outs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: drive(0, 1, 5, 5, 0, 0, 0, 0, 0, 0, STL);   // lw $5 then use rs=$5
        1: drive(0, 0, 5, 5, 0, 0, 0, 0, 0, 0, NORM);  // bubble cleared MemRd
        2: drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, NORM);  // load to $0
        3: drive(0, 1, 5, 1, 5, 0, 0, 0, 0, 0, NORM);  // rt match, rt unused
        4: drive(0, 1, 5, 1, 5, 1, 0, 0, 0, 0, STL);   // rt match, rt used
        5: drive(0, 0, 5, 1, 5, 1, 0, 0, 0, 0, NORM);
        default: drive(0, 0, 7, 7, 7, 1, 0, 0, 0, 0, NORM); // not a load
      endcase
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (outs !== exp_v) begin
        n_errors++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, outs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_muldiv;
    for (int i = 0; i < 17; i++) begin
      case (i)
        0:           drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ISS);        // mult at t
        1, 2, 3, 4:  drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, STL | 1);    // mflo held
        5:           drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);       // mflo at t+5
        6:           drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ISS);        // mult at t'
        7:           drive(0, 0, 0, 3, 4, 1, 0, 0, 0, 0, NORM | 1);   // add proceeds
        8, 9, 10:    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, STL | 1);    // div held
        11:          drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ISS);        // div at t'+5
        12, 13, 14, 15: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM | 1);
        default:     drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      endcase
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (outs !== exp_v) begin
        n_errors++;
        $display("FAIL muldiv[%0d]: got %b expected %b", i, outs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump;
    for (int i = 0; i < 10; i++) begin
      case (i)
`ifdef DELAY_SLOT_EN
        0: drive(0, 1, 5, 5, 0, 0, 0, 1, 0, 0, 6'b100100);       // branch + load-use
        1: drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, JMP);             // branch, no stall
        2: drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, NORM);            // jump keeps slot
        3: drive(0, 1, 5, 5, 0, 0, 1, 0, 0, 0, STL);             // stalled jump
        4: drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 6'b111010);       // delay-slot mult issues
        5, 6, 7, 8: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM | 1);
`else
        0: drive(0, 1, 5, 5, 0, 0, 0, 1, 0, 0, BRQ);             // branch beats load-use
        1: drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BRQ);
        2: drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, JMP);
        3: drive(0, 1, 5, 5, 0, 0, 1, 0, 0, 0, STL);             // stalled jump
        4: drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, BRQ);             // squashed mult
        5, 6, 7, 8: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);   // never went busy
`endif
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      endcase
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (outs !== exp_v) begin
        n_errors++;
        $display("FAIL branch_jump[%0d]: got %b expected %b", i, outs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_busy;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0:          drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ISS);        // mult at t
        1:          drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM | 1);
        2:          drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST | 1);    // state clears at edge
        3:          drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, RST);        // no issue in reset
        4:          drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ISS);        // issues immediately
        5, 6, 7, 8: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM | 1);
        default:    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      endcase
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (outs !== exp_v) begin
        n_errors++;
        $display("FAIL reset_mid_busy[%0d]: got %b expected %b", i, outs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_muldiv();
    test_branch_jump();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
